// File: rtl/pcm_pkg.sv
// Shared constants, defaults and types for the PCM serializer block.
package pcm_pkg;

  localparam int SAMPLE_W      = 16;
  localparam int BIT_IDX_W     = $clog2(SAMPLE_W);
  localparam int DEPTH_DEFAULT = 4;
  localparam int DIV_DEFAULT   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Increment an 8-bit counter, holding at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pcm_serializer_if.sv
// Upstream sample push / serial PCM output bundle of the serializer.
interface pcm_serializer_if
  import pcm_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
);

  logic                     Push;
  logic [SAMPLE_W-1:0]      Din;
  logic                     ClrOvf;
  logic                     SerOut;
  logic                     FrameSync;
  logic                     SerValid;
  logic                     Overflow;
  logic [7:0]               DropCnt;
  logic [$clog2(DEPTH):0]   Level;

  // Sample source / status observer side.
  modport master (
    output Push, Din, ClrOvf,
    input  SerOut, FrameSync, SerValid, Overflow, DropCnt, Level
  );

  // Serializer side.
  modport slave (
    input  Push, Din, ClrOvf,
    output SerOut, FrameSync, SerValid, Overflow, DropCnt, Level
  );

endinterface

// File: rtl/pcm_fifo.sv
// Sample FIFO: power-of-two depth, wrapping pointers, head visible
// combinationally so the serializer can load it on the popping edge.
module pcm_fifo
  import pcm_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                i_push,
  input  logic                i_pop,
  input  logic [SAMPLE_W-1:0] i_din,
  output logic [SAMPLE_W-1:0] o_head,
  output logic                o_full,
  output logic                o_empty,
  output logic [LW-1:0]       o_level
);

  logic [SAMPLE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [LW-1:0]       r_level;
  logic                w_push_ok;
  logic                w_pop_ok;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_head    = r_mem[r_rd_ptr];
  // A full FIFO still accepts a push when a pop frees the head slot.
  assign w_push_ok = i_push && (!o_full || i_pop);
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage write; contents are don't-care after reset since pointers restart.
  always_ff @(posedge Clock) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/pcm_serializer.sv
// Buffers 16-bit filter samples and shifts them out MSB first, DIV clocks
// per bit, with back-to-back words and overflow accounting.
module pcm_serializer
  import pcm_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int DIV   = DIV_DEFAULT
) (
  input logic              Clock,
  input logic              Reset,
  pcm_serializer_if.slave  bus
);

  localparam int            LW       = $clog2(DEPTH) + 1;
  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  ser_state_t           r_state, w_state_next;
  logic [SAMPLE_W-1:0]  r_shreg, w_shreg_next;
  logic [BIT_IDX_W-1:0] r_bit_idx, w_bit_idx_next;
  logic [CW-1:0]        r_div_cnt, w_div_cnt_next;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_drop;
  logic [SAMPLE_W-1:0]  w_head;
  logic [LW-1:0]        w_level;
  logic                 r_overflow;
  logic [7:0]           r_drop_cnt;

  pcm_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_push  (bus.Push),
    .i_pop   (w_pop),
    .i_din   (bus.Din),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // A sample is lost only when full and the serializer is not freeing a slot.
  assign w_drop = bus.Push && w_full && !w_pop;

  // Serializer state register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_idx <= '0;
      r_div_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_shreg   <= w_shreg_next;
      r_bit_idx <= w_bit_idx_next;
      r_div_cnt <= w_div_cnt_next;
    end
  end

  // Next-state: load a word from idle or straight after bit 0, else count bits.
  always_comb begin
    w_state_next   = r_state;
    w_shreg_next   = r_shreg;
    w_bit_idx_next = r_bit_idx;
    w_div_cnt_next = r_div_cnt;
    w_pop          = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_shreg_next   = w_head;
          w_bit_idx_next = BIT_IDX_W'(SAMPLE_W - 1);
          w_div_cnt_next = '0;
          w_state_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (r_div_cnt == DIV_LAST) begin
          w_div_cnt_next = '0;
          if (r_bit_idx == '0) begin
            if (!w_empty) begin
              w_pop          = 1'b1;
              w_shreg_next   = w_head;
              w_bit_idx_next = BIT_IDX_W'(SAMPLE_W - 1);
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_bit_idx_next = r_bit_idx - BIT_IDX_W'(1);
          end
        end else begin
          w_div_cnt_next = r_div_cnt + CW'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Sticky overflow and saturating drop count; a drop beats a same-edge clear.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      r_drop_cnt <= bus.ClrOvf ? 8'd1 : sat_inc8(r_drop_cnt);
    end else if (bus.ClrOvf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  // Outputs decode from registers only, so reset clears them at once.
  assign bus.SerValid  = (r_state == SHIFT);
  assign bus.SerOut    = (r_state == SHIFT) && r_shreg[r_bit_idx];
  assign bus.FrameSync = (r_state == SHIFT) && (r_bit_idx == BIT_IDX_W'(SAMPLE_W - 1));
  assign bus.Overflow  = r_overflow;
  assign bus.DropCnt   = r_drop_cnt;
  assign bus.Level     = w_level;

endmodule

// File: tb/tb_pcm_serializer.sv
// Directed bench: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_pcm_serializer;
  import pcm_pkg::*;

  localparam int DEPTH = 4;
  localparam int DIV   = 2;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  always #5 Clock = ~Clock;

  pcm_serializer_if #(.DEPTH(DEPTH)) bus();

  pcm_serializer #(
    .DEPTH (DEPTH),
    .DIV   (DIV)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic        push;
    logic [15:0] din;
    logic        clr;
    logic        so;
    logic        fs;
    logic        sv;
    logic        ovf;
    logic [7:0]  cnt;
    logic [2:0]  lvl;
  } vec_t;

  vec_t        tbl [9];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] got_q [$];
  logic [15:0] exp_words [5];
  logic [15:0] pat;
  int          mon_cyc  = 0;
  logic [15:0] mon_word = '0;

  // Rebuild shifted words: take each bit on the second cycle of its period.
  always @(negedge Clock or negedge Reset) begin
    if (!Reset) begin
      mon_cyc  = 0;
      mon_word = '0;
    end else if (bus.SerValid) begin
      if (mon_cyc % 2 == 1) mon_word = {mon_word[14:0], bus.SerOut};
      mon_cyc++;
      if (mon_cyc == 16 * DIV) begin
        got_q.push_back(mon_word);
        $display("word out 0x%04h", mon_word);
        mon_cyc = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic so, input logic fs, input logic sv,
                           input logic ovf, input logic [7:0] cnt, input logic [2:0] lvl);
    check({tag, " SerOut"},    32'(bus.SerOut),    32'(so));
    check({tag, " FrameSync"}, 32'(bus.FrameSync), 32'(fs));
    check({tag, " SerValid"},  32'(bus.SerValid),  32'(sv));
    check({tag, " Overflow"},  32'(bus.Overflow),  32'(ovf));
    check({tag, " DropCnt"},   32'(bus.DropCnt),   32'(cnt));
    check({tag, " Level"},     32'(bus.Level),     32'(lvl));
  endtask

  task automatic drive(input logic p, input logic [15:0] d, input logic c);
    bus.Push   = p;
    bus.Din    = d;
    bus.ClrOvf = c;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    while (bus.SerValid && n < bound) begin
      step();
      n++;
    end
    check({name, " drain in budget"}, 32'(n < bound), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // push, din, clr | SerOut, FrameSync, SerValid, Overflow, DropCnt, Level
    tbl[0] = '{1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1};
    tbl[1] = '{1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 3'd1};
    tbl[2] = '{1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 3'd2};
    tbl[3] = '{1'b1, 16'h4444, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3'd3};
    tbl[4] = '{1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3'd4};
    tbl[5] = '{1'b1, 16'h6666, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 3'd4};
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3'd4};
    tbl[7] = '{1'b1, 16'h7777, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1, 3'd4};
    tbl[8] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 3'd4};
    exp_words[0] = 16'h1111;
    exp_words[1] = 16'h2222;
    exp_words[2] = 16'h3333;
    exp_words[3] = 16'h4444;
    exp_words[4] = 16'h5555;

    drive(1'b0, 16'h0000, 1'b0);
    Reset = 1'b0;
    step();
    step();
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
    Reset = 1'b1;

    // Fill, overflow and clear-versus-drop, one edge per row.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].push, tbl[i].din, tbl[i].clr);
      step();
      $display("row %0d push=%0b din=0x%04h clr=%0b -> so=%0b fs=%0b sv=%0b ovf=%0b cnt=%0d lvl=%0d",
               i, tbl[i].push, tbl[i].din, tbl[i].clr, bus.SerOut, bus.FrameSync,
               bus.SerValid, bus.Overflow, bus.DropCnt, bus.Level);
      check_all($sformatf("row%0d", i), tbl[i].so, tbl[i].fs, tbl[i].sv,
                tbl[i].ovf, tbl[i].cnt, tbl[i].lvl);
    end
    drive(1'b0, 16'h0000, 1'b0);
    wait_idle(300, "burst");
    check("burst word count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      check($sformatf("burst word%0d", i), 32'(got_q[i]), 32'(exp_words[i]));
    end

    // Single word into an idle block: latency and bit timing.
    got_q.delete();
    drive(1'b1, 16'hA5C3, 1'b0);
    step();
    $display("push 0x%04h", 16'hA5C3);
    check("single pre SerValid", 32'(bus.SerValid), 32'd0);
    drive(1'b0, 16'h0000, 1'b0);
    pat = 16'hA5C3;
    for (int k = 0; k < 16 * DIV; k++) begin
      step();
      check($sformatf("single c%0d SerOut", k),    32'(bus.SerOut),    32'(pat[15 - k / DIV]));
      check($sformatf("single c%0d FrameSync", k), 32'(bus.FrameSync), 32'(k < DIV));
      check($sformatf("single c%0d SerValid", k),  32'(bus.SerValid),  32'd1);
    end
    step();
    check_all("single end", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);

    // Two words three cycles apart shift back to back.
    got_q.delete();
    drive(1'b1, 16'h8001, 1'b0);
    step();
    drive(1'b0, 16'h0000, 1'b0);
    for (int k = 0; k < 32 * DIV; k++) begin
      if (k == 2) drive(1'b1, 16'h7FFE, 1'b0);
      step();
      if (k == 2) drive(1'b0, 16'h0000, 1'b0);
      check($sformatf("b2b c%0d SerValid", k),  32'(bus.SerValid),  32'd1);
      check($sformatf("b2b c%0d FrameSync", k), 32'(bus.FrameSync),
            32'(k < DIV || (k >= 16 * DIV && k < 17 * DIV)));
    end
    step();
    check("b2b end SerValid", 32'(bus.SerValid), 32'd0);
    check("b2b word count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("b2b word0", 32'(got_q[0]), 32'h8001);
      check("b2b word1", 32'(got_q[1]), 32'h7FFE);
    end

    // Reset in the middle of bit 7 with two words queued.
    got_q.delete();
    drive(1'b1, 16'h1111, 1'b0);
    step();
    drive(1'b1, 16'h2222, 1'b0);
    step();
    drive(1'b1, 16'h3333, 1'b0);
    step();
    drive(1'b0, 16'h0000, 1'b0);
    repeat (15) step();
    check_all("pre-reset bit7", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3'd2);
    #2 Reset = 1'b0;
    #1 check_all("async reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
    step();
    step();
    Reset = 1'b1;
    drive(1'b1, 16'h0001, 1'b0);
    step();
    drive(1'b0, 16'h0000, 1'b0);
    step();
    check("post-reset SerValid", 32'(bus.SerValid), 32'd1);
    check("post-reset FrameSync", 32'(bus.FrameSync), 32'd1);
    wait_idle(100, "post-reset");
    check("post-reset word count", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check("post-reset word", 32'(got_q[0]), 32'h0001);

    // Continuous pushes: far more than 255 drops must saturate the counter.
    for (int i = 0; i < 360; i++) begin
      drive(1'b1, 16'(i), 1'b0);
      step();
    end
    drive(1'b0, 16'h0000, 1'b0);
    $display("saturation run ovf=%0b cnt=%0d", bus.Overflow, bus.DropCnt);
    check("sat DropCnt", 32'(bus.DropCnt), 32'd255);
    check("sat Overflow", 32'(bus.Overflow), 32'd1);
    wait_idle(300, "sat");
    check("sat hold DropCnt", 32'(bus.DropCnt), 32'd255);
    drive(1'b0, 16'h0000, 1'b1);
    step();
    drive(1'b0, 16'h0000, 1'b0);
    check("clear Overflow", 32'(bus.Overflow), 32'd0);
    check("clear DropCnt", 32'(bus.DropCnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
